// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: stall vector, exception flush and
// redirect PC, plus stall/exception statistics and a stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excep_type,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] excep_count,
  output logic             stall_timeout
);

  localparam int unsigned RUN_W    = $clog2(STALL_TIMEOUT);
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_NONE = 6'b000000;

  typedef enum logic {
    IDLE,
    FLUSHED
  } state_t;

  state_t             state, state_nxt;
  logic [5:0]         stall_enc;
  logic [RUN_W-1:0]   run_cnt;
  logic               stalled;

  // Priority MEM > EX > ID; each code leaves exactly one bubble point.
  always_comb begin
    stall_enc = STALL_NONE;
    if (stallreq_mem)      stall_enc = STALL_MEM;
    else if (stallreq_ex)  stall_enc = STALL_EX;
    else if (stallreq_id)  stall_enc = STALL_ID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are forced low while reset is asserted so they clear immediately.
  always_comb begin
    state_nxt = state;
    stall     = STALL_NONE;
    flush     = 1'b0;
    new_pc    = 32'h0;
    if (rst_n) begin
      if (state == IDLE && excep_type != 32'h0) begin
        flush     = 1'b1;
        new_pc    = (excep_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;
        state_nxt = FLUSHED;
      end else begin
        stall     = stall_enc;
        state_nxt = IDLE;
      end
    end
  end

  assign stalled = (stall != STALL_NONE);

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      excep_count  <= '0;
    end else begin
      if (stalled && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush && excep_count != '1)    excep_count  <= excep_count + CNT_W'(1);
    end
  end

  // Watchdog: run counter holds at its last value; timeout flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else if (stalled) begin
      if (run_cnt == RUN_W'(STALL_TIMEOUT - 1)) stall_timeout <= 1'b1;
      else                                      run_cnt <= run_cnt + RUN_W'(1);
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table with a scoreboard queue for
// the combinational outputs and a small model for counters and watchdog.
module tb_pipe_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excep_type, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles, excep_count;
  logic        stall_timeout;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .STALL_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excep_type(excep_type), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .excep_count(excep_count),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id, ex, mem;
    logic [31:0] exc, epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_sc, m_ec;
  int          m_run;
  logic        m_to;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic id, logic ex, logic mem, logic [31:0] exc,
                              logic [31:0] epc, logic [5:0] es, logic ef,
                              logic [31:0] ep);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(vec_t v);
    exp_t e;
    stallreq_id = v.id; stallreq_ex = v.ex; stallreq_mem = v.mem;
    excep_type = v.exc; cp0_epc = v.epc;
    sb.push_back('{v.e_stall, v.e_flush, v.e_pc});
    @(negedge clk);
    e = sb.pop_front();
    chk("stall",  32'(stall),  32'(e.stall));
    chk("flush",  32'(flush),  32'(e.flush));
    chk("new_pc", new_pc,      e.pc);
    @(posedge clk);
    if (e.stall != 6'b0) begin
      m_sc++;
      if (m_run == int'(TO) - 1) m_to = 1'b1;
      else m_run++;
    end else begin
      m_run = 0;
    end
    if (e.flush) m_ec++;
    #1;
    chk("stall_cycles",  stall_cycles,       m_sc);
    chk("excep_count",   excep_count,        m_ec);
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
  endtask

  task automatic model_reset();
    m_sc = '0; m_ec = '0; m_run = 0; m_to = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excep_type = '0; cp0_epc = '0;
    model_reset();

    // Main table: stall priority, exceptions, flush window behaviour.
    tbl.push_back(mk(0,0,0, 32'h0, 32'h0,        6'b000000, 0, 32'h0));
    tbl.push_back(mk(1,0,0, 32'h0, 32'h0,        6'b000111, 0, 32'h0));
    tbl.push_back(mk(1,1,0, 32'h0, 32'h0,        6'b001111, 0, 32'h0));
    tbl.push_back(mk(1,1,1, 32'h0, 32'h0,        6'b011111, 0, 32'h0));
    tbl.push_back(mk(0,0,0, 32'h0, 32'h0,        6'b000000, 0, 32'h0));
    tbl.push_back(mk(0,0,0, 32'h8, 32'h1234,     6'b000000, 1, 32'h20));
    tbl.push_back(mk(0,0,0, 32'h0, 32'h0,        6'b000000, 0, 32'h0));
    tbl.push_back(mk(0,0,0, 32'he, 32'hBFC00100, 6'b000000, 1, 32'hBFC00100));
    tbl.push_back(mk(0,0,0, 32'h0, 32'hBFC00100, 6'b000000, 0, 32'h0));
    tbl.push_back(mk(0,0,0, 32'hc, 32'h0,        6'b000000, 1, 32'h20));
    tbl.push_back(mk(0,0,0, 32'hc, 32'h0,        6'b000000, 0, 32'h0));
    tbl.push_back(mk(0,0,0, 32'h0, 32'h0,        6'b000000, 0, 32'h0));
    tbl.push_back(mk(0,0,1, 32'h1, 32'h0,        6'b000000, 1, 32'h20));
    tbl.push_back(mk(0,0,1, 32'h8, 32'h0,        6'b011111, 0, 32'h0));
    tbl.push_back(mk(0,1,0, 32'ha, 32'h0,        6'b000000, 1, 32'h20));
    tbl.push_back(mk(1,0,0, 32'h0, 32'h0,        6'b000111, 0, 32'h0));
    tbl.push_back(mk(0,0,0, 32'h0, 32'h0,        6'b000000, 0, 32'h0));

    #1;
    chk("rst_stall",        32'(stall),         32'h0);
    chk("rst_flush",        32'(flush),         32'h0);
    chk("rst_new_pc",       new_pc,             32'h0);
    chk("rst_stall_cycles", stall_cycles,       32'h0);
    chk("rst_excep_count",  excep_count,        32'h0);
    chk("rst_timeout",      32'(stall_timeout), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (i == 4) chk("stall_cycles_after_3", stall_cycles, 32'd3);
      if (i == 5) chk("excep_count_after_syscall", excep_count, 32'd1);
    end

    // Watchdog: a fresh stall run of TO cycles sets the sticky flag.
    for (int i = 0; i < int'(TO); i++) begin
      apply(mk(0,1,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0));
      if (i == int'(TO) - 2) chk("timeout_not_yet", 32'(stall_timeout), 32'h0);
    end
    chk("timeout_set", 32'(stall_timeout), 32'h1);
    apply(mk(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0));
    apply(mk(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0));
    chk("timeout_sticky", 32'(stall_timeout), 32'h1);

    // Asynchronous reset in the middle of a flush with a stall request pending.
    stallreq_ex = 1'b1; excep_type = 32'h8;
    #2;
    chk("preflush", 32'(flush), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall",        32'(stall),         32'h0);
    chk("mid_rst_flush",        32'(flush),         32'h0);
    chk("mid_rst_new_pc",       new_pc,             32'h0);
    chk("mid_rst_stall_cycles", stall_cycles,       32'h0);
    chk("mid_rst_excep_count",  excep_count,        32'h0);
    chk("mid_rst_timeout",      32'(stall_timeout), 32'h0);
    stallreq_ex = 1'b0; excep_type = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // FSM must be back in IDLE: an exception flushes immediately.
    apply(mk(0,0,0, 32'hd, 32'h0, 6'b000000, 1, 32'h20));
    apply(mk(0,1,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0));
    apply(mk(0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the OPEN_MIPS 5-stage core. It is the producer of the stall[5:0] vector and the flush pulse that every pipeline register consumes (pc_reg, if_id, id_ex, ex_mem, mem_wb). It arbitrates stall requests from ID/EX/MEM and exceptions reported by MEM, and supplies the redirect PC. It also keeps stall statistics and a stall watchdog.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for all exceptions except ERET
STALL_TIMEOUT, 16, consecutive stalled cycles before stall_timeout is set (must be >= 2)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  core clock
rst_n  input  1  reset
stallreq_id  input  1  ID stage requests stall (load-use hazard)
stallreq_ex  input  1  EX stage requests stall (multi-cycle div/madd)
stallreq_mem  input  1  MEM stage requests stall (bus wait)
excep_type  input  32  final exception code from MEM; 0 = none
cp0_epc  input  32  current CP0 EPC, already forwarded
stall  output  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb; 1 = hold
flush  output  1  clear all pipeline registers
new_pc  output  32  redirect target; valid only while flush=1
stall_cycles  output  CNT_W  count of cycles with stall != 0
excep_count  output  CNT_W  count of accepted exceptions
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. During reset: stall=0, flush=0, new_pc=0, counters=0, stall_timeout=0, state=IDLE, run counter=0.
- States: IDLE, FLUSHED.
- IDLE:
  - excep_type != 0 → flush=1 in the same cycle (combinational), stall=6'b000000, new_pc selected, excep_count +1, next state FLUSHED.
  - Otherwise flush=0.
- FLUSHED: lasts exactly 1 cycle.
  - flush=0, new_pc=0.
  - Any excep_type input is ignored; the pipeline holds only bubbles at this point.
  - Stall requests are honoured normally.
  - Next state IDLE.
- new_pc selection:
  - excep_type == 32'h0000_000e (ERET) → cp0_epc.
  - Any other nonzero code (0x1 int, 0x8 syscall, 0xa RI, 0xc ovf, 0xd trap) → EXC_VECTOR.
  - new_pc = 0 whenever flush = 0.
- stall encoding (combinational, when flush=0; priority MEM > EX > ID):
  - stallreq_mem → 6'b011111
  - stallreq_ex → 6'b001111
  - stallreq_id → 6'b000111
  - none → 6'b000000
- Boundary stall rule: stall[k]=1 and stall[k+1]=0 makes the stage-k register insert a bubble. The encodings above guarantee exactly one bubble point.
- Simultaneous exception and stall request: flush wins. stall is forced to 0, and the stall counters treat the cycle as unstalled.
- stall_cycles: increments on every clk edge where stall != 0. It saturates at all-ones and does not wrap.
- excep_count: increments once per flush cycle. It saturates at all-ones.
- Watchdog:
  - An internal run counter increments while stall != 0. It resets to 0 on any cycle with stall == 0, including flush cycles.
  - When the run counter reaches STALL_TIMEOUT-1 while still stalled, stall_timeout sets on the next edge.
  - stall_timeout stays set until reset.
- Latency: stall, flush and new_pc are 0-cycle combinational from their inputs. Counters and stall_timeout are updated 1 cycle after the triggering input.
- Reset mid-flush: all outputs clear immediately (asynchronous reset), and the FSM returns to IDLE.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with stallreq_ex=1 → stall=0, flush=0, stall_cycles=0, stall_timeout=0 immediately.
- Stall priority: stallreq_id=1 → stall=6'b000111; add stallreq_ex → 6'b001111; add stallreq_mem → 6'b011111; release all → 6'b000000, with stall_cycles=3 after 3 stalled edges.
- Syscall: excep_type=32'h8 for 1 cycle → flush=1 and new_pc=32'h20 that cycle; next cycle flush=0; excep_count=1.
- ERET: cp0_epc=32'hBFC0_0100, excep_type=32'he → new_pc=32'hBFC0_0100, flush=1.
- Back-to-back exceptions: excep_type=32'hc held for 2 cycles → flush=1 in cycle 1 only; excep_count=1.
- Exception with stall, and watchdog: excep_type=32'h1 together with stallreq_mem=1 → flush=1, stall=0, stall_cycles unchanged. Then stallreq_ex held for 16 cycles with default parameters → stall_timeout=1 after the 16th edge. Releasing the request leaves stall_timeout at 1.
